// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: opcode encodings, FSM states
// and the width helper for the load-return counter.
package wb_pkg;

  localparam logic [4:0] OPC_RTYPE = 5'b00000;
  localparam logic [4:0] OPC_JAL   = 5'b00011;
  localparam logic [4:0] OPC_ADDI  = 5'b00101;
  localparam logic [4:0] OPC_LW    = 5'b01000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_LD = 2'd1,
    ST_DRAIN   = 2'd2
  } wb_state_e;

  // Counter must be able to hold the value n itself.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/writeback_ctrl_pipe_if.sv
// Bundle of MEM-stage inputs, load-return inputs and register-file write
// outputs of the writeback stage, plus the FSM state for observation.
interface writeback_ctrl_pipe_if import wb_pkg::*; #(
  parameter int DW = 32,
  parameter int AW = 5
) ();
  // Handshake: an instruction is taken at a rising edge when in_valid=1,
  // stall_in=0, flush_in=0 and wb_busy=0; otherwise upstream holds it.
  // mem_rvalid is a one-cycle pulse with no backpressure.
  logic          in_valid;
  logic [31:0]   in_instr;
  logic [DW-1:0] in_alu;
  logic [DW-1:0] in_pc1;
  logic          in_exc;
  logic [DW-1:0] in_exc_code;
  logic          stall_in;
  logic          flush_in;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          wb_wren;
  logic [AW-1:0] wb_reg;
  logic [DW-1:0] wb_data;
  logic          wb_busy;
  logic          jal_signal;
  logic          lw_signal;
  logic          ld_timeout;
  wb_state_e     dbg_state;

  modport slave (
    input  in_valid, in_instr, in_alu, in_pc1, in_exc, in_exc_code,
           stall_in, flush_in, mem_rvalid, mem_rdata,
    output wb_wren, wb_reg, wb_data, wb_busy, jal_signal, lw_signal,
           ld_timeout, dbg_state
  );

  modport master (
    output in_valid, in_instr, in_alu, in_pc1, in_exc, in_exc_code,
           stall_in, flush_in, mem_rvalid, mem_rdata,
    input  wb_wren, wb_reg, wb_data, wb_busy, jal_signal, lw_signal,
           ld_timeout, dbg_state
  );

endinterface

// File: rtl/wb_decode.sv
// Combinational writeback decode: which instructions write, where, and
// whether the write waits for a load return. An exception overrides the opcode.
module wb_decode import wb_pkg::*; #(
  parameter int AW         = 5,
  parameter int LINK_REG   = 31,
  parameter int STATUS_REG = 30
) (
  input  logic [31:0]   instr_i,
  input  logic          exc_i,
  output logic          is_write_o,
  output logic          is_jal_o,
  output logic          is_lw_o,
  output logic [AW-1:0] dest_o
);

  logic [4:0]    opc;
  logic [AW-1:0] rd;
  logic          unused_instr_bits;

  assign opc               = instr_i[31:27];
  assign rd                = instr_i[26:27-AW];
  assign unused_instr_bits = ^instr_i[26-AW:0];

  always_comb begin
    is_write_o = 1'b0;
    is_jal_o   = 1'b0;
    is_lw_o    = 1'b0;
    dest_o     = rd;
    if (exc_i) begin
      is_write_o = 1'b1;
      dest_o     = AW'(STATUS_REG);
    end else begin
      case (opc)
        OPC_RTYPE, OPC_ADDI: is_write_o = 1'b1;
        OPC_JAL: begin
          is_write_o = 1'b1;
          is_jal_o   = 1'b1;
          dest_o     = AW'(LINK_REG);
        end
        OPC_LW: begin
          is_write_o = 1'b1;
          is_lw_o    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/writeback_ctrl_pipe.sv
// MEM/WB stage: registered register-file write port with variable-latency
// load return, load timeout status write, flush/drain and r0 suppression.
module writeback_ctrl_pipe import wb_pkg::*; #(
  parameter int DW            = 32,
  parameter int AW            = 5,
  parameter int LINK_REG      = 31,
  parameter int STATUS_REG    = 30,
  parameter int LD_TIMEOUT    = 16,
  parameter int TIMEOUT_CODE  = 7,
  parameter int ZERO_SUPPRESS = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  writeback_ctrl_pipe_if.slave  bus
);

  localparam int            CW       = cnt_width(LD_TIMEOUT);
  localparam logic [CW-1:0] TMO_CNT  = CW'(LD_TIMEOUT);
  localparam logic [AW-1:0] STATUS_A = AW'(STATUS_REG);
  localparam logic [DW-1:0] TMO_DATA = DW'(TIMEOUT_CODE);

  wb_state_e     state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rd_q;
  logic          wren_q, jal_q, lw_q, tmo_q;
  logic [AW-1:0] reg_q;
  logic [DW-1:0] data_q;

  logic          dec_write, dec_jal, dec_lw;
  logic [AW-1:0] dec_dest;
  logic          capture;

  wb_decode #(
    .AW         (AW),
    .LINK_REG   (LINK_REG),
    .STATUS_REG (STATUS_REG)
  ) u_decode (
    .instr_i    (bus.in_instr),
    .exc_i      (bus.in_exc),
    .is_write_o (dec_write),
    .is_jal_o   (dec_jal),
    .is_lw_o    (dec_lw),
    .dest_o     (dec_dest)
  );

  // State is checked inside the FSM; this is the upstream-side condition only.
  assign capture = bus.in_valid & ~bus.stall_in & ~bus.flush_in;
  assign cnt_d   = cnt_q + CW'(1);

  function automatic logic wr_ok(input logic [AW-1:0] r);
    return !((ZERO_SUPPRESS != 0) && (r == '0));
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      wren_q  <= 1'b0;
      reg_q   <= '0;
      data_q  <= '0;
      jal_q   <= 1'b0;
      lw_q    <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      wren_q <= 1'b0;
      jal_q  <= 1'b0;
      lw_q   <= 1'b0;
      tmo_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (capture) begin
            if (dec_lw) begin
              state_q <= ST_WAIT_LD;
              cnt_q   <= '0;
              rd_q    <= dec_dest;
            end else if (dec_write) begin
              wren_q <= wr_ok(dec_dest);
              reg_q  <= dec_dest;
              data_q <= bus.in_exc ? bus.in_exc_code
                                   : (dec_jal ? bus.in_pc1 : bus.in_alu);
              jal_q  <= dec_jal;
            end
          end
        end
        ST_WAIT_LD: begin
          if (bus.flush_in) begin
            // A return arriving with the flush is already accounted for.
            cnt_q   <= '0;
            state_q <= bus.mem_rvalid ? ST_IDLE : ST_DRAIN;
          end else if (bus.mem_rvalid) begin
            wren_q  <= wr_ok(rd_q);
            reg_q   <= rd_q;
            data_q  <= bus.mem_rdata;
            lw_q    <= 1'b1;
            state_q <= ST_IDLE;
          end else if (cnt_d == TMO_CNT) begin
            wren_q  <= wr_ok(STATUS_A);
            reg_q   <= STATUS_A;
            data_q  <= TMO_DATA;
            tmo_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_DRAIN;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_DRAIN: begin
          if (bus.flush_in) begin
            cnt_q <= '0;
          end else if (bus.mem_rvalid || (cnt_d == TMO_CNT)) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.wb_wren    = wren_q;
  assign bus.wb_reg     = reg_q;
  assign bus.wb_data    = data_q;
  assign bus.wb_busy    = (state_q != ST_IDLE);
  assign bus.jal_signal = jal_q;
  assign bus.lw_signal  = lw_q;
  assign bus.ld_timeout = tmo_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_writeback_ctrl_pipe.sv
// Directed bench for writeback_ctrl_pipe: a vector table for single-cycle
// writes, then hand-written sequences for load return, timeout, flush, reset.
module tb_writeback_ctrl_pipe;
  import wb_pkg::*;

  logic clock;
  logic reset;
  int   tests;
  int   failed;
  int   n;
  logic anyw;

  writeback_ctrl_pipe_if #(.DW(32), .AW(5)) bus ();

  writeback_ctrl_pipe #(
    .DW(32), .AW(5), .LINK_REG(31), .STATUS_REG(30), .LD_TIMEOUT(16),
    .TIMEOUT_CODE(7), .ZERO_SUPPRESS(1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic        valid;
    logic [4:0]  opc;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc1;
    logic        exc;
    logic [31:0] code;
    logic        stall;
    logic        flush;
    logic        e_wren;
    logic        chk_d;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic        e_jal;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  function automatic vec_t mkv(logic valid, logic [4:0] opc, logic [4:0] rd,
                               logic [31:0] alu, logic [31:0] pc1, logic exc,
                               logic [31:0] code, logic stall, logic flush,
                               logic e_wren, logic chk_d, logic [4:0] e_reg,
                               logic [31:0] e_data, logic e_jal);
    vec_t v;
    v.valid = valid; v.opc = opc; v.rd = rd; v.alu = alu; v.pc1 = pc1;
    v.exc = exc; v.code = code; v.stall = stall; v.flush = flush;
    v.e_wren = e_wren; v.chk_d = chk_d; v.e_reg = e_reg; v.e_data = e_data;
    v.e_jal = e_jal;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    bus.in_valid    = 1'b0;
    bus.in_instr    = 32'h0;
    bus.in_alu      = 32'h0;
    bus.in_pc1      = 32'h0;
    bus.in_exc      = 1'b0;
    bus.in_exc_code = 32'h0;
    bus.stall_in    = 1'b0;
    bus.flush_in    = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = 32'h0;
  endtask

  task automatic drive_instr(input logic [4:0] opc, input logic [4:0] rd,
                             input logic [31:0] alu, input logic [31:0] pc1);
    bus.in_valid = 1'b1;
    bus.in_instr = {opc, rd, 22'h15A5A5};
    bus.in_alu   = alu;
    bus.in_pc1   = pc1;
    bus.in_exc   = 1'b0;
  endtask

  task automatic start_lw(input logic [4:0] rd);
    drive_instr(OPC_LW, rd, 32'hDEAD, 32'h0);
    tick();
    idle_in();
  endtask

  task automatic wait_timeout(input string name);
    n = 0;
    while (bus.ld_timeout !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(name, n, 16);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    reset  = 1'b1;
    idle_in();

    vecs[0]  = mkv(1, OPC_RTYPE, 5,  32'h1234, 32'h0,    0, 32'h0,  0, 0, 1, 1, 5,  32'h1234, 0);
    vecs[1]  = mkv(1, OPC_JAL,   9,  32'h99,   32'h40,   0, 32'h0,  0, 0, 1, 1, 31, 32'h40,   1);
    vecs[2]  = mkv(1, OPC_ADDI,  0,  32'h55,   32'h0,    0, 32'h0,  0, 0, 0, 1, 0,  32'h55,   0);
    vecs[3]  = mkv(1, OPC_ADDI,  12, 32'hCAFE, 32'h8,    0, 32'h0,  0, 0, 1, 1, 12, 32'hCAFE, 0);
    vecs[4]  = mkv(1, 5'b00001,  3,  32'h11,   32'h0,    0, 32'h0,  0, 0, 0, 0, 0,  32'h0,    0);
    vecs[5]  = mkv(1, OPC_RTYPE, 7,  32'h22,   32'h0,    0, 32'h0,  1, 0, 0, 0, 0,  32'h0,    0);
    vecs[6]  = mkv(1, OPC_RTYPE, 7,  32'h22,   32'h0,    0, 32'h0,  0, 1, 0, 0, 0,  32'h0,    0);
    vecs[7]  = mkv(0, OPC_RTYPE, 7,  32'h22,   32'h0,    0, 32'h0,  0, 0, 0, 0, 0,  32'h0,    0);
    vecs[8]  = mkv(1, OPC_RTYPE, 4,  32'h33,   32'h0,    1, 32'h11, 0, 0, 1, 1, 30, 32'h11,   0);
    vecs[9]  = mkv(1, OPC_LW,    9,  32'h44,   32'h0,    1, 32'h3,  0, 0, 1, 1, 30, 32'h3,    0);
    vecs[10] = mkv(1, OPC_JAL,   0,  32'h0,    32'h1000, 0, 32'h0,  0, 0, 1, 1, 31, 32'h1000, 1);
    vecs[11] = mkv(1, OPC_RTYPE, 0,  32'h77,   32'h0,    0, 32'h0,  0, 0, 0, 1, 0,  32'h77,   0);
    vecs[12] = mkv(1, 5'b11111,  6,  32'h88,   32'h0,    0, 32'h0,  0, 0, 0, 0, 0,  32'h0,    0);

    // Reset state
    tick();
    tick();
    chk("rst_wren", bus.wb_wren, 0);
    chk("rst_reg", bus.wb_reg, 0);
    chk("rst_data", bus.wb_data, 0);
    chk("rst_busy", bus.wb_busy, 0);
    chk("rst_jal", bus.jal_signal, 0);
    chk("rst_lw", bus.lw_signal, 0);
    chk("rst_tmo", bus.ld_timeout, 0);
    chk("rst_state", bus.dbg_state, ST_IDLE);
    reset = 1'b0;

    // Back-to-back single-cycle vectors
    for (int i = 0; i < NV; i++) begin
      bus.in_valid    = vecs[i].valid;
      bus.in_instr    = {vecs[i].opc, vecs[i].rd, 22'h15A5A5};
      bus.in_alu      = vecs[i].alu;
      bus.in_pc1      = vecs[i].pc1;
      bus.in_exc      = vecs[i].exc;
      bus.in_exc_code = vecs[i].code;
      bus.stall_in    = vecs[i].stall;
      bus.flush_in    = vecs[i].flush;
      tick();
      chk($sformatf("v%0d_wren", i), bus.wb_wren, vecs[i].e_wren);
      if (vecs[i].chk_d) begin
        chk($sformatf("v%0d_reg", i), bus.wb_reg, vecs[i].e_reg);
        chk($sformatf("v%0d_data", i), bus.wb_data, vecs[i].e_data);
      end
      chk($sformatf("v%0d_jal", i), bus.jal_signal, vecs[i].e_jal);
      chk($sformatf("v%0d_lw", i), bus.lw_signal, 0);
      chk($sformatf("v%0d_busy", i), bus.wb_busy, 0);
    end
    idle_in();
    tick();
    chk("after_vec_wren", bus.wb_wren, 0);

    // Load return three cycles after capture
    start_lw(5'd9);
    chk("lw_busy1", bus.wb_busy, 1);
    chk("lw_wren1", bus.wb_wren, 0);
    tick();
    chk("lw_busy2", bus.wb_busy, 1);
    tick();
    chk("lw_busy3", bus.wb_busy, 1);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBEEF;
    tick();
    idle_in();
    chk("lw_wren", bus.wb_wren, 1);
    chk("lw_reg", bus.wb_reg, 9);
    chk("lw_data", bus.wb_data, 32'hBEEF);
    chk("lw_sig", bus.lw_signal, 1);
    chk("lw_idle", bus.wb_busy, 0);
    tick();
    chk("lw_wren_off", bus.wb_wren, 0);
    chk("lw_sig_off", bus.lw_signal, 0);

    // Timeout, then a late return is absorbed
    start_lw(5'd4);
    wait_timeout("tmo_cycles");
    chk("tmo_wren", bus.wb_wren, 1);
    chk("tmo_reg", bus.wb_reg, 30);
    chk("tmo_data", bus.wb_data, 7);
    chk("tmo_busy", bus.wb_busy, 1);
    tick();
    chk("tmo_pulse_off", bus.ld_timeout, 0);
    chk("drain_wren", bus.wb_wren, 0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555;
    tick();
    idle_in();
    chk("late_wren", bus.wb_wren, 0);
    chk("late_idle", bus.wb_busy, 0);

    // Return on the same edge the timeout would fire: data wins
    start_lw(5'd2);
    repeat (15) tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hABCD;
    tick();
    idle_in();
    chk("race_wren", bus.wb_wren, 1);
    chk("race_data", bus.wb_data, 32'hABCD);
    chk("race_tmo", bus.ld_timeout, 0);
    chk("race_idle", bus.wb_busy, 0);

    // Flush in WAIT_LD, late return drains, then a normal write
    anyw = 1'b0;
    start_lw(5'd6);
    anyw |= bus.wb_wren;
    tick();
    anyw |= bus.wb_wren;
    bus.flush_in = 1'b1;
    tick();
    bus.flush_in = 1'b0;
    anyw |= bus.wb_wren;
    chk("fl_drain", bus.dbg_state, ST_DRAIN);
    tick();
    anyw |= bus.wb_wren;
    tick();
    anyw |= bus.wb_wren;
    bus.mem_rvalid = 1'b1;
    tick();
    idle_in();
    anyw |= bus.wb_wren;
    chk("fl_nowrite", anyw, 0);
    chk("fl_idle", bus.wb_busy, 0);
    drive_instr(OPC_RTYPE, 5'd3, 32'h77, 32'h0);
    tick();
    idle_in();
    chk("fl_add_wren", bus.wb_wren, 1);
    chk("fl_add_reg", bus.wb_reg, 3);
    chk("fl_add_data", bus.wb_data, 32'h77);

    // Flush and return on the same edge in WAIT_LD
    start_lw(5'd8);
    bus.flush_in   = 1'b1;
    bus.mem_rvalid = 1'b1;
    tick();
    idle_in();
    chk("flrv_wren", bus.wb_wren, 0);
    chk("flrv_idle", bus.wb_busy, 0);

    // Return while idle is ignored
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h999;
    tick();
    idle_in();
    chk("idle_rv_wren", bus.wb_wren, 0);
    chk("idle_rv_busy", bus.wb_busy, 0);

    // Flush in DRAIN restarts the drain count
    start_lw(5'd10);
    wait_timeout("tmo2_cycles");
    repeat (3) tick();
    bus.flush_in = 1'b1;
    tick();
    bus.flush_in = 1'b0;
    chk("drfl_busy", bus.wb_busy, 1);
    n = 0;
    while (bus.wb_busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("drfl_cycles", n, 16);

    // Reset in WAIT_LD
    drive_instr(OPC_ADDI, 5'd11, 32'hF00D, 32'h0);
    tick();
    start_lw(5'd12);
    tick();
    chk("rs_pre_busy", bus.wb_busy, 1);
    reset = 1'b1;
    tick();
    chk("rs_wren", bus.wb_wren, 0);
    chk("rs_reg", bus.wb_reg, 0);
    chk("rs_data", bus.wb_data, 0);
    chk("rs_busy", bus.wb_busy, 0);
    chk("rs_lw", bus.lw_signal, 0);
    chk("rs_state", bus.dbg_state, ST_IDLE);
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/writeback_ctrl_pipe.md
Name: writeback_ctrl_pipe

Overview:
- Parametrised writeback stage for the pipelined processor: MEM/WB stage register, writeback decode, write-data select and register-file write port drive.
- Adds over the previous combinational writeback decode:
  - registered outputs;
  - variable-latency load return (mem_rvalid handshake) with timeout;
  - exception status write;
  - flush with drain of orphaned load returns;
  - r0 write suppression.
- Sits between the memory stage and the register file; drives the stall logic via wb_busy.

Parameters:
- DW, 32, data width of ALU result, PC+1, load data and write data.
- AW, 5, register address width; rd field is instr[26:22] when AW=5, generally instr[26:27-AW].
- LINK_REG, 31, destination register for jal.
- STATUS_REG, 30, destination register for exception and timeout status writes.
- LD_TIMEOUT, 16, cycles waited for mem_rvalid before a timeout; must be ≥1; counter width is clog2(LD_TIMEOUT+1).
- TIMEOUT_CODE, 7, value written to STATUS_REG on load timeout (zero-extended to DW).
- ZERO_SUPPRESS, 1, when 1, any write targeting r0 has wb_wren forced to 0.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  MEM-stage instruction present.
- in_instr  in  32  instruction; opcode is [31:27].
- in_alu  in  DW  ALU result.
- in_pc1  in  DW  PC+1 (jal link value).
- in_exc  in  1  instruction raised an exception.
- in_exc_code  in  DW  status value for the exception.
- stall_in  in  1  downstream hold; blocks capture.
- flush_in  in  1  kill in-flight instruction.
- mem_rvalid  in  1  load data valid, single-cycle pulse.
- mem_rdata  in  DW  load data.
- wb_wren  out  1  register-file write enable.
- wb_reg  out  AW  write register number.
- wb_data  out  DW  write data.
- wb_busy  out  1  stage not accepting; equals state≠IDLE.
- jal_signal  out  1  registered: the current write is a jal link write.
- lw_signal  out  1  registered: the current write is a load return.
- ld_timeout  out  1  one-cycle pulse accompanying a timeout status write.

Behaviour:
- Reset: state=IDLE, counter=0. wb_wren, wb_reg, wb_data, jal_signal, lw_signal and ld_timeout are all 0. A reset asserted in any state (including WAIT_LD and DRAIN) returns to these values next cycle.
- Decode:
  - writers are opcodes 00000 (R-type), 00011 (jal), 00101 (addi), 01000 (lw); all other opcodes produce no write;
  - jal: dest=LINK_REG, data=in_pc1;
  - lw: dest=rd, data=mem_rdata;
  - others: dest=rd, data=in_alu;
  - in_exc=1 overrides the opcode: dest=STATUS_REG, data=in_exc_code, always a write, never enters WAIT_LD.
- Capture: occurs at an edge when in_valid & ~stall_in & ~flush_in & state==IDLE. While busy, in_valid is ignored and upstream must hold the instruction.
- Latency:
  - non-load write: wb_wren=1 for exactly one cycle, starting the cycle after capture;
  - throughput is one instruction per cycle in IDLE.
- States:
  - IDLE: on capture of a non-exception lw, go to WAIT_LD, clear counter, no write.
  - WAIT_LD:
    - mem_rvalid=1 at an edge: latch mem_rdata, pulse wb_wren next cycle with lw_signal=1, return to IDLE;
    - otherwise increment counter;
    - counter reaching LD_TIMEOUT: write TIMEOUT_CODE to STATUS_REG, pulse ld_timeout, go to DRAIN.
  - DRAIN:
    - absorb one late mem_rvalid without writing, then go to IDLE;
    - if no mem_rvalid arrives within LD_TIMEOUT cycles, go to IDLE anyway.
- Flush: flush_in=1 at an edge means the next-cycle wb_wren=0 and no capture occurs.
  - flush in WAIT_LD goes to DRAIN, counter cleared;
  - flush in DRAIN restarts the DRAIN count;
  - flush does not retract a wb_wren already visible in the current cycle.
- Simultaneous events:
  - flush and in_valid: flush wins;
  - flush and mem_rvalid in WAIT_LD: data discarded, go to IDLE, no DRAIN;
  - mem_rvalid and counter==LD_TIMEOUT in the same cycle: data wins;
  - mem_rvalid in IDLE: ignored.
- r0 write: with ZERO_SUPPRESS=1, wb_wren=0 but wb_reg and wb_data still update.
- Data path: wb_data is not zero-extended or sign-extended, except TIMEOUT_CODE, which is zero-extended to DW.

Decomposition:
- Shared package wb_pkg:
  - opcode constants OPC_RTYPE, OPC_JAL, OPC_ADDI, OPC_LW;
  - state enum for IDLE, WAIT_LD, DRAIN;
  - a width helper for the counter.
- One sub-module, wb_decode: purely combinational. Inputs are instr, exc and LINK_REG/STATUS_REG. Outputs are is_write, is_jal, is_lw and dest.

Test Plan:
- R-type rd=5, in_alu=0x1234, captured at cycle 0 → cycle 1: wb_wren=1, wb_reg=5, wb_data=0x1234; cycle 2: wb_wren=0.
- jal with in_pc1=0x40 → wb_reg=31, wb_data=0x40, jal_signal=1; back-to-back addi rd=0 → wb_wren=0 next cycle.
- lw rd=9, mem_rvalid with data 0xBEEF 3 cycles after capture → wb_busy=1 for 3 cycles; one cycle later wb_wren=1, wb_reg=9, wb_data=0xBEEF, lw_signal=1.
- lw with no rvalid → after 16 cycles wb_reg=30, wb_data=7, ld_timeout=1; a late rvalid 2 cycles later produces no write and returns to IDLE.
- Flush in WAIT_LD cycle 2, rvalid at cycle 5 → no writes at any point; IDLE after the rvalid; next add writes normally.
- in_exc=1 with code 0x3 on an lw → wb_reg=30, wb_data=3 one cycle later, never busy. Reset asserted mid-WAIT_LD → all outputs 0 next cycle.
